// File: rtl/fpg8_pkg.sv
// Shared FPG8 datapath constants, opcode type and flag-class test.
package fpg8_pkg;

  localparam int WORD_W    = 16;
  localparam int PSW_Z_BIT = 0;
  localparam int PSW_N_BIT = 1;
  localparam logic [WORD_W-1:0] PSW_RESET_VAL = 16'h0000;

  typedef logic [3:0] opcode_t;

  // Opcodes 4'b1000..4'b1111 form the flag-setting ALU class.
  function automatic logic is_flag_class(input opcode_t op);
    return op[3];
  endfunction

endpackage

// File: rtl/psw_flag_logic.sv
// Qualifies an ALU flag capture and supplies the next Z/N bits for the PSW.
module psw_flag_logic
  import fpg8_pkg::*;
(
  input  opcode_t ir_opcode,
  input  logic    ir_s,
  input  logic    z_in,
  input  logic    cc_z_in,
  input  logic    cc_n_in,
  output logic    update_en,
  output logic    next_z,
  output logic    next_n
);

  assign update_en = z_in & ir_s & is_flag_class(ir_opcode);
  assign next_z    = cc_z_in;
  assign next_n    = cc_n_in;

endmodule

// File: rtl/program_status_word.sv
// FPG8 program status word: bus-loadable register with optional Z/N flag capture
// (flag path present only when PSW_FLAG_UPDATE_EN is defined) and a tri-state bus driver.
module program_status_word
  import fpg8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  inout  wire  [WORD_W-1:0] DATA,
  output logic [WORD_W-1:0] REG_OUT_PSW,
  input  logic              latch,
  input  logic              enable,
  input  logic [3:0]        IR_opcode,
  input  logic              IR_S,
  input  logic              Z_in,
  input  logic              CC_Z_in,
  input  logic              CC_N_in
);

  logic update_en;
  logic next_z;
  logic next_n;

  psw_flag_logic u_flag_logic (
    .ir_opcode (IR_opcode),
    .ir_s      (IR_S),
    .z_in      (Z_in),
    .cc_z_in   (CC_Z_in),
    .cc_n_in   (CC_N_in),
    .update_en (update_en),
    .next_z    (next_z),
    .next_n    (next_n)
  );

`ifndef PSW_FLAG_UPDATE_EN
  logic unused_flag_path;
  assign unused_flag_path = ^{update_en, next_z, next_n};
`endif

  assign DATA = enable ? REG_OUT_PSW : {WORD_W{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      REG_OUT_PSW <= PSW_RESET_VAL;
    end else if (latch) begin
      // Latching while driving the bus would read back our own value; hold explicitly.
      REG_OUT_PSW <= enable ? REG_OUT_PSW : DATA;
`ifdef PSW_FLAG_UPDATE_EN
    end else if (update_en) begin
      REG_OUT_PSW[PSW_Z_BIT] <= next_z;
      REG_OUT_PSW[PSW_N_BIT] <= next_n;
`endif
    end
  end

endmodule

// File: tb/tb_program_status_word.sv
// Self-checking bench for program_status_word against a behavioural PSW model.
module tb_program_status_word;

`ifdef PSW_FLAG_UPDATE_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, latch, enable, ir_s, z_in, cc_z, cc_n;
  logic [3:0]  ir_opcode;
  logic [15:0] tb_bus_val;
  logic [15:0] psw_out;
  wire  [15:0] DATA;

  logic [15:0] model_psw;
  int checks   = 0;
  int failures = 0;

  // The bench drives the bus only while the DUT is not driving it.
  assign DATA = enable ? 16'bz : tb_bus_val;

  always #5 clk = ~clk;

  program_status_word dut (
    .clk         (clk),
    .reset       (reset),
    .DATA        (DATA),
    .REG_OUT_PSW (psw_out),
    .latch       (latch),
    .enable      (enable),
    .IR_opcode   (ir_opcode),
    .IR_S        (ir_s),
    .Z_in        (z_in),
    .CC_Z_in     (cc_z),
    .CC_N_in     (cc_n)
  );

  function automatic logic [15:0] ref_next(input logic [15:0] cur);
    if (reset) return 16'h0000;
    if (latch) return enable ? cur : tb_bus_val;
    if (FLAGS_ON && z_in && ir_s && (ir_opcode >= 4'd8))
      return {cur[15:2], cc_n, cc_z};
    return cur;
  endfunction

  task automatic idle_inputs();
    reset = 0; latch = 0; enable = 0; ir_s = 0; z_in = 0;
    cc_z = 0; cc_n = 0; ir_opcode = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_psw = ref_next(model_psw);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1; tb_bus_val = 16'hC3C3;
    model_psw = 16'hFFFF;
    tick();
    checks++;
    if (psw_out !== 16'h0000) begin
      failures++; $display("FAIL reset_psw got=%h exp=%h", psw_out, 16'h0000);
    end
    checks++;
    if (DATA !== 16'hC3C3) begin
      failures++; $display("FAIL reset_bus_released got=%h exp=%h", DATA, 16'hC3C3);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    idle_inputs();
    latch = 1; tb_bus_val = 16'hABAA;
    tick();
    checks++;
    if (psw_out !== 16'hABAA) begin
      failures++; $display("FAIL load got=%h exp=%h", psw_out, 16'hABAA);
    end
    @(negedge clk);
    latch = 0; tb_bus_val = 16'h0F0F;
    tick(); tick();
    checks++;
    if (psw_out !== 16'hABAA) begin
      failures++; $display("FAIL load_hold got=%h exp=%h", psw_out, 16'hABAA);
    end
  endtask

  task automatic test_flag_update();
    logic [15:0] exp;
    @(negedge clk);
    idle_inputs();
    ir_opcode = 4'b1000; ir_s = 1; z_in = 1; cc_z = 1; cc_n = 0;
    tick();
    exp = FLAGS_ON ? 16'hABA9 : 16'hABAA;
    checks++;
    if (psw_out !== exp) begin
      failures++; $display("FAIL flag_update got=%h exp=%h", psw_out, exp);
    end
    @(negedge clk);
    ir_s = 0; cc_z = 0; cc_n = 1;
    tick();
    checks++;
    if (psw_out !== exp) begin
      failures++; $display("FAIL flag_no_s got=%h exp=%h", psw_out, exp);
    end
    @(negedge clk);
    ir_s = 1; ir_opcode = 4'b0011;
    tick();
    checks++;
    if (psw_out !== exp) begin
      failures++; $display("FAIL flag_wrong_class got=%h exp=%h", psw_out, exp);
    end
    @(negedge clk);
    ir_opcode = 4'b1111; z_in = 0;
    tick();
    checks++;
    if (psw_out !== exp) begin
      failures++; $display("FAIL flag_no_strobe got=%h exp=%h", psw_out, exp);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle_inputs();
    latch = 1; tb_bus_val = 16'hABAA;
    ir_opcode = 4'b1010; ir_s = 1; z_in = 1; cc_z = 1; cc_n = 1;
    tick();
    checks++;
    if (psw_out !== 16'hABAA) begin
      failures++; $display("FAIL latch_over_flags got=%h exp=%h", psw_out, 16'hABAA);
    end
    @(negedge clk);
    reset = 1; tb_bus_val = 16'h5555;
    tick();
    checks++;
    if (psw_out !== 16'h0000) begin
      failures++; $display("FAIL reset_over_latch got=%h exp=%h", psw_out, 16'h0000);
    end
  endtask

  task automatic test_bus_drive();
    @(negedge clk);
    idle_inputs();
    latch = 1; tb_bus_val = 16'h1234;
    tick();
    @(negedge clk);
    latch = 0; enable = 1;
    #1;
    checks++;
    if (DATA !== 16'h1234) begin
      failures++; $display("FAIL bus_drive got=%h exp=%h", DATA, 16'h1234);
    end
    // Illegal latch-while-driving must leave the PSW unchanged.
    @(negedge clk);
    latch = 1;
    tick();
    checks++;
    if (psw_out !== 16'h1234) begin
      failures++; $display("FAIL latch_with_enable got=%h exp=%h", psw_out, 16'h1234);
    end
    @(negedge clk);
    latch = 0; enable = 0; tb_bus_val = 16'h5A5A;
    #1;
    checks++;
    if (DATA !== 16'h5A5A) begin
      failures++; $display("FAIL bus_release got=%h exp=%h", DATA, 16'h5A5A);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4] = '{16'h0001, 16'hFFFE, 16'h8000, 16'h7FFF};
    @(negedge clk);
    idle_inputs();
    latch = 1;
    for (int i = 0; i < 4; i++) begin
      tb_bus_val = vals[i];
      tick();
      checks++;
      if (psw_out !== vals[i]) begin
        failures++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, psw_out, vals[i]);
      end
      @(negedge clk);
    end
    latch = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(15) == 0);
      latch      = ($urandom_range(3) == 0);
      enable     = ($urandom_range(3) == 0);
      ir_opcode  = 4'($urandom_range(15));
      ir_s       = 1'($urandom_range(1));
      z_in       = 1'($urandom_range(1));
      cc_z       = 1'($urandom_range(1));
      cc_n       = 1'($urandom_range(1));
      tb_bus_val = 16'($urandom);
      tick();
      checks++;
      if (psw_out !== model_psw) begin
        failures++; $display("FAIL random_psw[%0d] got=%h exp=%h", i, psw_out, model_psw);
      end
      if (enable) begin
        checks++;
        if (DATA !== model_psw) begin
          failures++; $display("FAIL random_bus[%0d] got=%h exp=%h", i, DATA, model_psw);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    tb_bus_val = 16'h0000;
    model_psw  = 16'h0000;
    test_reset();
    test_load();
    test_flag_update();
    test_priority();
    test_bus_drive();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
